tta_add_fu: RTL

- Responder end of the TTA transport interface for the adder function unit.
- Receives operand and trigger moves from N transport lanes and computes add/sub per lane.
- Returns each result with its destination register tag to the writeback side using a valid/ready handshake.
- One independent 2-stage pipeline per lane; sits between the transport buses and register-file writeback of the riscv core.

---
 rtl/tta_add_fu.sv | 92 +++++++++
 1 files changed

// File: rtl/tta_add_fu.sv
// Adder function unit for the TTA transport interface: N independent lanes, each with an
// operand register, a bypassed add/sub trigger and a two-stage valid/ready result pipeline.
module tta_add_fu #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned N    = 4,
   parameter int unsigned RW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    opd_we,
   input  logic [N*XLEN-1:0] opd_data,
   input  logic [N-1:0]    trig_valid,
   input  logic [N*XLEN-1:0] trig_data,
   input  logic [N-1:0]    trig_sub,
   input  logic [N*RW-1:0] trig_dest,
   output logic [N-1:0]    trig_ready,
   output logic [N-1:0]    res_valid,
   output logic [N*XLEN-1:0] res_data,
   output logic [N*RW-1:0] res_dest,
   input  logic [N-1:0]    res_ready,
   output logic            busy
);

   logic [N-1:0] ex_v_all;
   logic [N-1:0] out_v_all;

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic [XLEN-1:0] opd_reg;
      logic [XLEN-1:0] ex_data;
      logic [XLEN-1:0] out_data;
      logic [RW-1:0]   ex_dest;
      logic [RW-1:0]   out_dest;
      logic            ex_v;
      logic            out_v;
      logic            out_adv;
      logic            ex_adv;
      logic            fire;
      logic [XLEN-1:0] op_a;
      logic [XLEN-1:0] op_b;
      logic [XLEN-1:0] result;

      always_comb begin
         out_adv = ~out_v | res_ready[i];
         ex_adv  = ~ex_v | out_adv;
         fire    = trig_valid[i] & ex_adv;
         // A same-cycle operand write is forwarded into the computation.
         op_a    = opd_we[i] ? opd_data[i*XLEN +: XLEN] : opd_reg;
         op_b    = trig_data[i*XLEN +: XLEN];
         result  = trig_sub[i] ? (op_a - op_b) : (op_a + op_b);
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            opd_reg  <= '0;
            ex_data  <= '0;
            ex_dest  <= '0;
            ex_v     <= 1'b0;
            out_data <= '0;
            out_dest <= '0;
            out_v    <= 1'b0;
         end else begin
            if (opd_we[i]) begin
               opd_reg <= opd_data[i*XLEN +: XLEN];
            end
            if (fire) begin
               ex_data <= result;
               ex_dest <= trig_dest[i*RW +: RW];
               ex_v    <= 1'b1;
            end else if (ex_adv) begin
               ex_v <= 1'b0;
            end
            if (out_adv) begin
               if (ex_v) begin
                  out_data <= ex_data;
                  out_dest <= ex_dest;
               end
               out_v <= ex_v;
            end
         end
      end

      assign trig_ready[i]            = ex_adv;
      assign res_valid[i]             = out_v;
      assign res_data[i*XLEN +: XLEN] = out_data;
      assign res_dest[i*RW +: RW]     = out_dest;
      assign ex_v_all[i]              = ex_v;
      assign out_v_all[i]             = out_v;
   end

   assign busy = |(ex_v_all | out_v_all);

endmodule
